// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO drain/packer slice.
package fifo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Width of a word-count field able to hold 0..ratio
  function automatic int unsigned cnt_width(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

  function automatic int unsigned beat_width(input int unsigned wid, input int unsigned ratio);
    return wid * ratio;
  endfunction

endpackage

// File: rtl/packer_idle_timer.sv
// Idle-cycle counter for the word packer; expire marks the cycle in which the
// count reaches TMO-1, so the caller can close the beat on that same edge.
module packer_idle_timer
#(
  parameter  int unsigned TMO = 64,
  localparam int unsigned TW  = (TMO > 1) ? $clog2(TMO) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic softreset,
  input  logic inc,
  input  logic clr,
  output logic expire
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (softreset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != TW'(TMO - 1))) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expire = inc && (cnt == TW'(TMO - 2));

endmodule

// File: rtl/fifo_word_packer.sv
// Pops WID-bit words from a sync FIFO and packs RATIO of them into one valid/ready beat.
// Optional idle auto-flush is built when PACKER_TIMEOUT_EN is defined.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter  int unsigned WID   = 32,
  parameter  int unsigned RATIO = 4,
  parameter  int unsigned TMO   = 64,
  localparam int unsigned CWID  = cnt_width(RATIO),
  localparam int unsigned BW    = beat_width(WID, RATIO)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            softreset,
  input  logic            empty,
  input  logic [WID-1:0]  fifodata,
  output logic            readout,
  input  logic            flush,
  output logic            vout,
  input  logic            rdy,
  output logic [BW-1:0]   dout,
  output logic [CWID-1:0] dcount,
  output logic            partial
);

  localparam int unsigned IW = $clog2(RATIO);

  if (RATIO < 2 || TMO < 2) begin : g_bad_cfg
    $error("fifo_word_packer: RATIO and TMO must both be at least 2");
  end

  state_e          state;
  state_e          state_nxt;
  logic [IW-1:0]   idx;
  logic [WID-1:0]  slots [RATIO];
  logic [BW-1:0]   beat;
  logic [CWID-1:0] held;
  logic            consume;
  logic            full;
  logic            close;
  logic            close_part;
  logic            expire;

`ifdef PACKER_TIMEOUT_EN
  logic tmr_inc;
  logic tmr_clr;

  assign tmr_inc = (state == FILL) && (idx != '0) && !readout;
  assign tmr_clr = readout || close;

  packer_idle_timer #(
    .TMO (TMO)
  ) u_idle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .softreset (softreset),
    .inc       (tmr_inc),
    .clr       (tmr_clr),
    .expire    (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else if (softreset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (close) state_nxt = HOLD;
      HOLD:    if (consume) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // FIFO pop and beat-close decisions; a flush with nothing held is dropped
  always_comb begin
    readout    = !empty && ((state == FILL) || ((state == HOLD) && rdy));
    consume    = (state == HOLD) && rdy;
    held       = CWID'(idx) + CWID'(readout);
    full       = readout && (state == FILL) && (idx == IW'(RATIO - 1));
    close      = 1'b0;
    close_part = 1'b0;
    if (state == FILL) begin
      if (full) begin
        close = 1'b1;
      end else if ((flush || expire) && (held != '0)) begin
        close      = 1'b1;
        close_part = 1'b1;
      end
    end
  end

  // Beat as it would look after this cycle's pop lands in its slot
  always_comb begin
    beat = '0;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (readout && (state == FILL) && (idx == IW'(i))) begin
        beat[i*WID +: WID] = fifodata;
      end else begin
        beat[i*WID +: WID] = slots[i];
      end
    end
  end

  // Slot array, fill index and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      vout    <= 1'b0;
      dout    <= '0;
      dcount  <= '0;
      partial <= 1'b0;
      for (int i = 0; i < int'(RATIO); i++) slots[i] <= '0;
    end else if (softreset) begin
      idx     <= '0;
      vout    <= 1'b0;
      dout    <= '0;
      dcount  <= '0;
      partial <= 1'b0;
      for (int i = 0; i < int'(RATIO); i++) slots[i] <= '0;
    end else begin
      if (consume) begin
        vout <= 1'b0;
        for (int i = 0; i < int'(RATIO); i++) slots[i] <= '0;
        if (readout) begin
          slots[0] <= fifodata;
          idx      <= IW'(1);
        end else begin
          idx <= '0;
        end
      end else if ((state == FILL) && readout) begin
        slots[idx] <= fifodata;
        if (!full) idx <= idx + IW'(1);
      end
      if (close) begin
        vout    <= 1'b1;
        dout    <= beat;
        dcount  <= held;
        partial <= close_part;
      end
    end
  end

endmodule
